// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - handshaked integer ALU with registered result and iterative RV32M multiply/divide
//
// Ports:
//   clk        in   1     clock, rising edge
//   rstn       in   1     asynchronous active-low reset
//   flush      in   1     synchronous abort of any in-flight or held op
//   in_valid   in   1     request valid
//   in_ready   out  1     unit accepts a request this cycle
//   src0       in   XLEN  operand A (rs1)
//   src1       in   XLEN  operand B (rs2)
//   aluop      in   5     operation code
//   out_valid  out  1     result register holds a valid result
//   out_ready  in   1     consumer takes the result this cycle
//   result     out  XLEN  registered result

module alu_iter #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] src0,
    input  logic [XLEN-1:0] src1,
    input  logic [4:0]      aluop,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_SLT   = 5'd2;
    localparam logic [4:0] OP_XOR   = 5'd3;
    localparam logic [4:0] OP_AND   = 5'd4;
    localparam logic [4:0] OP_OR    = 5'd5;
    localparam logic [4:0] OP_SLL   = 5'd6;
    localparam logic [4:0] OP_SRL   = 5'd7;
    localparam logic [4:0] OP_SRA   = 5'd8;
    localparam logic [4:0] OP_SLTU  = 5'd9;
    localparam logic [4:0] OP_MUL   = 5'd10;
    localparam logic [4:0] OP_MULH  = 5'd11;
    localparam logic [4:0] OP_MULHU = 5'd12;
    localparam logic [4:0] OP_DIV   = 5'd13;
    localparam logic [4:0] OP_DIVU  = 5'd14;
    localparam logic [4:0] OP_REM   = 5'd15;
    localparam logic [4:0] OP_REMU  = 5'd16;

    localparam logic [XLEN-1:0] XMIN     = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [SHW:0]    CNT_INIT = (SHW+1)'(XLEN);
    localparam logic [SHW:0]    CNT_LAST = (SHW+1)'(1);

    logic [1:0]        state;
    logic [2*XLEN-1:0] acc;      // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]   opb;      // multiplicand (mul) or divisor (div) magnitude
    logic [SHW:0]      cnt;
    logic [4:0]        op_q;
    logic              neg_q;    // negate product (mul) or quotient (div)
    logic              neg_r;    // negate remainder (div)
    logic [XLEN-1:0]   result_q;
    logic              out_valid_q;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic            accept;
    logic            signed_op;
    logic            is_mul;
    logic            is_div;
    logic            div_zero;
    logic            div_ovf;
    logic            fast;
    logic [XLEN-1:0] mag0;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] fast_res;
    logic [SHW-1:0]  shamt;

    assign in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign accept   = in_valid && in_ready && !flush;

    assign shamt     = src1[SHW-1:0];
    assign is_mul    = (aluop == OP_MUL) || (aluop == OP_MULH) || (aluop == OP_MULHU);
    assign is_div    = (aluop == OP_DIV) || (aluop == OP_DIVU) ||
                       (aluop == OP_REM) || (aluop == OP_REMU);
    // MUL is treated as signed; the low half is identical either way.
    assign signed_op = (aluop == OP_MUL) || (aluop == OP_MULH) ||
                       (aluop == OP_DIV) || (aluop == OP_REM);
    assign div_zero  = (src1 == '0);
    assign div_ovf   = (src0 == XMIN) && (src1 == '1) &&
                       ((aluop == OP_DIV) || (aluop == OP_REM));

    // Division corner cases never enter the iterative loop.
    assign fast = !(is_mul || is_div) || (is_div && (div_zero || div_ovf));

    assign mag0 = (signed_op && src0[XLEN-1]) ? -src0 : src0;
    assign mag1 = (signed_op && src1[XLEN-1]) ? -src1 : src1;

    always_comb begin
        fast_res = '0;
        case (aluop)
            OP_ADD:  fast_res = src0 + src1;
            OP_SUB:  fast_res = src0 - src1;
            OP_SLT:  fast_res = {{(XLEN-1){1'b0}}, ($signed(src0) < $signed(src1))};
            OP_XOR:  fast_res = src0 ^ src1;
            OP_AND:  fast_res = src0 & src1;
            OP_OR:   fast_res = src0 | src1;
            OP_SLL:  fast_res = src0 << shamt;
            OP_SRL:  fast_res = src0 >> shamt;
            OP_SRA:  fast_res = XLEN'($signed(src0) >>> shamt);
            OP_SLTU: fast_res = {{(XLEN-1){1'b0}}, (src0 < src1)};
            // Only reached for divisor zero or signed overflow.
            OP_DIV, OP_DIVU: fast_res = div_zero ? '1 : XMIN;
            OP_REM, OP_REMU: fast_res = div_zero ? src0 : '0;
            default: fast_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // One iteration of shift-add multiply / restoring divide
    // ------------------------------------------------------------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] mul_prod;
    logic [XLEN-1:0]   mul_res;

    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    assign mul_next = {mul_sum, acc[XLEN-1:1]};
    assign mul_prod = neg_q ? -mul_next : mul_next;
    assign mul_res  = (op_q == OP_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [XLEN-1:0]   div_quo;
    logic [XLEN-1:0]   div_rem;
    logic [XLEN-1:0]   div_res;

    // Remainder stays below the divisor, so the shifted value fits XLEN+1 bits
    // and a set top bit of the difference means the trial subtract borrowed.
    assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opb};
    assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};
    assign div_quo   = neg_q ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
    assign div_rem   = neg_r ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
    assign div_res   = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? div_quo : div_rem;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            acc         <= '0;
            opb         <= '0;
            cnt         <= '0;
            op_q        <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            // result_q deliberately keeps its last value.
            state       <= S_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if ((state == S_DONE) && out_ready) begin
                        state       <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end
                    if (accept) begin
                        if (fast) begin
                            result_q    <= fast_res;
                            out_valid_q <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            out_valid_q <= 1'b0;
                            op_q        <= aluop;
                            cnt         <= CNT_INIT;
                            if (is_mul) begin
                                acc   <= {{XLEN{1'b0}}, mag1};
                                opb   <= mag0;
                                neg_q <= signed_op && (src0[XLEN-1] ^ src1[XLEN-1]);
                                neg_r <= 1'b0;
                                state <= S_MUL;
                            end else begin
                                acc   <= {{XLEN{1'b0}}, mag0};
                                opb   <= mag1;
                                neg_q <= signed_op && (src0[XLEN-1] ^ src1[XLEN-1]);
                                neg_r <= signed_op && src0[XLEN-1];
                                state <= S_DIV;
                            end
                        end
                    end
                end
                S_MUL: begin
                    acc <= mul_next;
                    cnt <= cnt - 1'b1;
                    // The last iteration also applies the sign and loads the result.
                    if (cnt == CNT_LAST) begin
                        result_q    <= mul_res;
                        out_valid_q <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                S_DIV: begin
                    acc <= div_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_LAST) begin
                        result_q    <= div_res;
                        out_valid_q <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign result    = result_q;
    assign out_valid = out_valid_q;

endmodule
